// File: rtl/harness_pkg.sv
// harness_pkg: shared sequencer state encoding, lock synchroniser depth and counter sizing helper.
package harness_pkg;
  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } harness_state_t;
  localparam int LOCK_SYNC_STAGES = 2;
  // $clog2 of a count, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flop synchroniser with asynchronous active-low clear.
// Ports: clk, rst_n (async clear), d_i (asynchronous input), q_o (output after STAGES flops).
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] stage_q [STAGES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end
  assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/tt_fpga_harness.sv
// tt_fpga_harness: board-side reset sequencer and pin conditioning for a Tiny Tapeout core.
// Ports: clk/rst_n harness clock and async reset; pll_locked raw lock; pin_ui -> ui_in synchronised
// inputs; core_rst_n/core_ena core control; core_uio_out/oe -> pad_uio_out/oe registered pad
// drive (zero outside RUN); pad_uio_in -> core_uio_in synchronised pad input; state sequencer
// state; heartbeat status LED. Optional macro HARNESS_HEARTBEAT_EN adds a divided LED blink.
module tt_fpga_harness
  import harness_pkg::*;
#(
  parameter int UI_WIDTH    = 8,
  parameter int UIO_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RESET_HOLD  = 1024,
  parameter int HB_BITS     = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  input  logic [UI_WIDTH-1:0]  pin_ui,
  output logic [UI_WIDTH-1:0]  ui_in,
  output logic                 core_rst_n,
  output logic                 core_ena,
  input  logic [UIO_WIDTH-1:0] core_uio_out,
  input  logic [UIO_WIDTH-1:0] core_uio_oe,
  output logic [UIO_WIDTH-1:0] core_uio_in,
  input  logic [UIO_WIDTH-1:0] pad_uio_in,
  output logic [UIO_WIDTH-1:0] pad_uio_out,
  output logic [UIO_WIDTH-1:0] pad_uio_oe,
  output logic [1:0]           state,
  output logic                 heartbeat
);
  localparam int FW = cnt_width(LOCK_FILTER);
  localparam int HW = cnt_width(RESET_HOLD);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  harness_state_t state_q, state_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic run_q, run_d, lock_s;
  logic [UIO_WIDTH-1:0] pad_out_q, pad_oe_q;
  sync_ff #(.WIDTH(1), .STAGES(LOCK_SYNC_STAGES)) u_lock_sync (
    .clk(clk), .rst_n(rst_n), .d_i(pll_locked), .q_o(lock_s)
  );
  sync_ff #(.WIDTH(UI_WIDTH), .STAGES(SYNC_STAGES)) u_ui_sync (
    .clk(clk), .rst_n(rst_n), .d_i(pin_ui), .q_o(ui_in)
  );
  sync_ff #(.WIDTH(UIO_WIDTH), .STAGES(SYNC_STAGES)) u_uio_sync (
    .clk(clk), .rst_n(rst_n), .d_i(pad_uio_in), .q_o(core_uio_in)
  );
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    case (state_q)
      ST_RESET: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (!lock_s) begin
          filt_d = '0;
        end else if (filt_q == FILT_LAST) begin
          state_d = ST_HOLD;
          filt_d  = '0;
          hold_d  = '0;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          filt_d  = '0;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          filt_d  = '0;
          hold_d  = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end
  // Core controls and pad drive follow the next state so they change on the very edge the
  // sequencer enters or leaves RUN, releasing the pads without an extra cycle of drive.
  assign run_d = (state_d == ST_RUN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      filt_q    <= '0;
      hold_q    <= '0;
      run_q     <= 1'b0;
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      hold_q    <= hold_d;
      run_q     <= run_d;
      pad_out_q <= run_d ? core_uio_out : '0;
      pad_oe_q  <= run_d ? core_uio_oe : '0;
    end
  end
  assign state       = state_q;
  assign core_rst_n  = run_q;
  assign core_ena    = run_q;
  assign pad_uio_out = pad_out_q;
  assign pad_uio_oe  = pad_oe_q;
`ifdef HARNESS_HEARTBEAT_EN
  logic [HB_BITS-1:0] hb_q, hb_d;
  assign hb_d = (state_q == ST_RUN) ? hb_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb_q <= '0;
    else hb_q <= hb_d;
  end
  // Blink while running; solid on while waiting for a lock that is absent.
  assign heartbeat = (state_q == ST_RUN) ? hb_q[HB_BITS-1] : (state_q == ST_WAIT_LOCK) & ~lock_s;
`else
  assign heartbeat = run_q & (HB_BITS > 0);
`endif
endmodule
